if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage sitting directly upstream of the instruction memory. It owns the program counter, drives the PC into the asynchronous instruction memory, and captures the returned word together with its PC into the IF/ID pipeline register for the decoder. It supports pipeline stall and branch/jump redirect with flush. Misaligned redirect targets are trapped, so the instruction memory never sees a non-word-aligned PC.

Parameters:
PC_WIDTH, 32, width of PC and all address fields
INST_WIDTH, 32, instruction word width
RESET_VECTOR, 32'h0000_0000, PC value after reset (must be word-aligned)
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
pc_o  output  PC_WIDTH  current PC; drives instruction memory address combinationally
inst_i  input  INST_WIDTH  instruction word from instruction memory (same-cycle read)
stall_i  input  1  hazard unit: hold PC and IF/ID
redirect_i  input  1  taken branch/jump from execute
redirect_pc_i  input  PC_WIDTH  redirect target
ifid_valid_o  output  1  IF/ID holds a real instruction
ifid_pc_o  output  PC_WIDTH  PC of captured instruction
ifid_pc4_o  output  PC_WIDTH  PC+4 of captured instruction (link value)
ifid_inst_o  output  INST_WIDTH  captured instruction, NOP_INST when invalid
trap_o  output  1  misaligned-fetch trap pending
trap_pc_o  output  PC_WIDTH  offending redirect target
fetch_cnt_o  output  32  count of instructions delivered to IF/ID

Behaviour:
- Reset, synchronous on the clk edge with rst=1: pc=RESET_VECTOR; ifid_valid_o=0; ifid_pc_o=0; ifid_pc4_o=0; ifid_inst_o=NOP_INST; trap_o=0; trap_pc_o=0; fetch_cnt_o=0; state=RUN. Reset mid-operation overrides every other input.
- pc_o is the PC register output, with no combinational path from inputs. The read is zero latency: the inst_i of cycle N belongs to the pc_o of cycle N.
- States:
  - RUN: normal fetch.
  - TRAP: fetch halted.
- Priority per edge in RUN: rst > redirect_i > stall_i > normal.
  - Normal (no redirect, no stall): IF/ID <= {valid=1, pc_o, pc_o+4, inst_i}; pc <= pc_o+4; fetch_cnt_o += 1.
  - Stall, no redirect: pc, IF/ID and fetch_cnt_o hold.
  - Redirect with redirect_pc_i[1:0]==0: pc <= redirect_pc_i; IF/ID flushed (valid=0, inst=NOP_INST, pc fields hold); no count. This applies even when stall_i=1 that cycle.
  - Redirect with redirect_pc_i[1:0]!=0: state <= TRAP; trap_o <= 1; trap_pc_o <= redirect_pc_i; pc holds its aligned value; IF/ID flushed.
- TRAP:
  - PC and IF/ID hold, with IF/ID invalid (NOP). stall_i is ignored.
  - An aligned redirect clears trap_o, loads pc, and returns to RUN. trap_pc_o keeps its last value.
  - A misaligned redirect updates trap_pc_o and stays in TRAP.
- Arithmetic:
  - PC+4 is modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 0 with no flag.
  - fetch_cnt_o wraps modulo 2^32.
- Invariant: pc_o[1:0]==2'b00 at all times.

Decomposition:
- Shared package riscv_pkg holds:
  - constants NOP_INST and RESET_VECTOR;
  - typedef if_state_t {RUN, TRAP};
  - struct ifid_t {valid, pc, pc4, inst}, also consumed by the decoder.
- Sub-module pc_reg holds the PC register, next-PC mux (pc+4 / redirect / hold) and the alignment check.
- The IF/ID register, FSM and counter stay in if_stage.

Test Plan:
1. rst for 2 cycles, then run 4 cycles with memory words A0..A3 at 0x0..0xC -> pc_o 0,4,8,C,10; ifid (0x0,A0,0x4) through (0xC,A3,0x10), valid=1; fetch_cnt_o=4.
2. stall_i=1 for 3 cycles at pc_o=0x8 -> pc_o stays 0x8; IF/ID frozen at (0x4,A1); counter frozen. On release, the next capture is (0x8,A2).
3. redirect_i=1 with target 0x40, same cycle as stall_i=1 -> next pc_o=0x40; ifid_valid_o=0 and ifid_inst_o=0x00000013; the following cycle ifid=(0x40,mem[0x40]).
4. Redirect target 0x42 -> trap_o=1, trap_pc_o=0x42, pc_o unchanged and aligned, IF/ID invalid for 5 idle cycles. Then redirect to 0x80 -> trap_o=0, pc_o=0x80, fetching resumes.
5. Redirect to 0xFFFF_FFFC, run 2 cycles -> ifid_pc4_o=0x0 and pc_o wraps to 0x0; no trap.
6. Assert rst mid-stream during a redirect/stall -> the next cycle shows all outputs at reset values and pc_o=RESET_VECTOR; rst beats redirect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch constants, IF state encoding,
// the IF/ID pipeline record and the fetch alignment helper.
package riscv_pkg;

    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned INST_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] NOP_INST     = 32'h0000_0013; // addi x0,x0,0

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } if_state_t;

    // IF/ID pipeline record as seen by the decoder.
    typedef struct packed {
        logic                  valid;
        logic [PC_WIDTH-1:0]   pc;
        logic [PC_WIDTH-1:0]   pc4;
        logic [INST_WIDTH-1:0] inst;
    } ifid_t;

    // A fetch address is legal only on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC mux (redirect / pc+4 / hold)
// and the alignment check on the redirect target.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned        PC_WIDTH     = riscv_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance_i,
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] target_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus4_o,
    output logic                target_misaligned_o
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Sequential increment wraps naturally at the top of the address space.
    assign pc_plus4_o          = pc_q + PC_STEP;
    assign target_misaligned_o = ~is_word_aligned(target_i[1:0]);
    assign pc_o                = pc_q;

    // Next-PC select: a load (only ever an aligned target) beats advance, else hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_plus4_o;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset to the reset vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the PC into the asynchronous instruction
// memory, captures word+PC into IF/ID, handles stall, redirect/flush and
// traps misaligned redirect targets so memory only ever sees aligned PCs.
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = riscv_pkg::PC_WIDTH,
    parameter int unsigned          INST_WIDTH   = riscv_pkg::INST_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter logic [INST_WIDTH-1:0] NOP_INST     = riscv_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   pc_o,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  ifid_valid_o,
    output logic [PC_WIDTH-1:0]   ifid_pc_o,
    output logic [PC_WIDTH-1:0]   ifid_pc4_o,
    output logic [INST_WIDTH-1:0] ifid_inst_o,
    output logic                  trap_o,
    output logic [PC_WIDTH-1:0]   trap_pc_o,
    output logic [31:0]           fetch_cnt_o
);

    if_state_t             state_q;
    logic                  ifid_valid_q;
    logic [PC_WIDTH-1:0]   ifid_pc_q;
    logic [PC_WIDTH-1:0]   ifid_pc4_q;
    logic [INST_WIDTH-1:0] ifid_inst_q;
    logic                  trap_q;
    logic [PC_WIDTH-1:0]   trap_pc_q;
    logic [31:0]           fetch_cnt_q;

    logic [PC_WIDTH-1:0]   pc_s;
    logic [PC_WIDTH-1:0]   pc_plus4_s;
    logic                  misaligned_s;
    logic                  load_s;
    logic                  advance_s;

    pc_reg #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk                 (clk),
        .rst                 (rst),
        .advance_i           (advance_s),
        .load_i              (load_s),
        .target_i            (redirect_pc_i),
        .pc_o                (pc_s),
        .pc_plus4_o          (pc_plus4_s),
        .target_misaligned_o (misaligned_s)
    );

    // PC control: aligned redirects load in either state; only RUN advances, and only when free.
    always_comb begin
        load_s    = redirect_i & ~misaligned_s;
        advance_s = 1'b0;
        case (state_q)
            RUN:     advance_s = ~redirect_i & ~stall_i;
            TRAP:    advance_s = 1'b0;
            default: advance_s = 1'b0;
        endcase
    end

    // Fetch FSM with IF/ID register, trap registers and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= {PC_WIDTH{1'b0}};
            ifid_pc4_q   <= {PC_WIDTH{1'b0}};
            ifid_inst_q  <= NOP_INST;
            trap_q       <= 1'b0;
            trap_pc_q    <= {PC_WIDTH{1'b0}};
            fetch_cnt_q  <= 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect_i) begin
                        // Flush the wrong-path word; pc fields keep their last value.
                        ifid_valid_q <= 1'b0;
                        ifid_inst_q  <= NOP_INST;
                        if (misaligned_s) begin
                            state_q   <= TRAP;
                            trap_q    <= 1'b1;
                            trap_pc_q <= redirect_pc_i;
                        end
                    end else if (!stall_i) begin
                        ifid_valid_q <= 1'b1;
                        ifid_pc_q    <= pc_s;
                        ifid_pc4_q   <= pc_plus4_s;
                        ifid_inst_q  <= inst_i;
                        fetch_cnt_q  <= fetch_cnt_q + 32'd1;
                    end
                end
                TRAP: begin
                    if (redirect_i) begin
                        if (misaligned_s) begin
                            trap_pc_q <= redirect_pc_i;
                        end else begin
                            state_q <= RUN;
                            trap_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= RUN;
                    ifid_valid_q <= 1'b0;
                    ifid_inst_q  <= NOP_INST;
                end
            endcase
        end
    end

    assign pc_o         = pc_s;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_inst_o  = ifid_inst_q;
    assign trap_o       = trap_q;
    assign trap_pc_o    = trap_pc_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural reference model pushes the
// expected post-edge state into a scoreboard queue as each cycle's stimulus is
// driven; after the edge the entry is popped and compared with the DUT.
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RVEC  = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] inst;
        logic        trap;
        logic [31:0] tpc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_s;
    logic [31:0] inst_s;
    logic        stall_s;
    logic        redirect_s;
    logic [31:0] redirect_pc_s;
    logic        ifid_valid_s;
    logic [31:0] ifid_pc_s;
    logic [31:0] ifid_pc4_s;
    logic [31:0] ifid_inst_s;
    logic        trap_s;
    logic [31:0] trap_pc_s;
    logic [31:0] fetch_cnt_s;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    exp_t exp_q[$];

    // reference model state
    logic        m_trap_state;
    exp_t        m;

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 ^ (addr * 32'h9E37_79B9) ^ {addr[29:0], 2'b01};
    endfunction

    assign inst_s = mem_word(pc_s);

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pc_s),
        .inst_i        (inst_s),
        .stall_i       (stall_s),
        .redirect_i    (redirect_s),
        .redirect_pc_i (redirect_pc_s),
        .ifid_valid_o  (ifid_valid_s),
        .ifid_pc_o     (ifid_pc_s),
        .ifid_pc4_o    (ifid_pc4_s),
        .ifid_inst_o   (ifid_inst_s),
        .trap_o        (trap_s),
        .trap_pc_o     (trap_pc_s),
        .fetch_cnt_o   (fetch_cnt_s)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge.
    task automatic model_step(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        if (r) begin
            m_trap_state = 1'b0;
            m.pc = RVEC; m.valid = 1'b0; m.ipc = 32'd0; m.ipc4 = 32'd0;
            m.inst = NOP; m.trap = 1'b0; m.tpc = 32'd0; m.cnt = 32'd0;
        end else if (!m_trap_state) begin
            if (rd) begin
                m.valid = 1'b0;
                m.inst  = NOP;
                if (tgt[1:0] != 2'b00) begin
                    m_trap_state = 1'b1;
                    m.trap = 1'b1;
                    m.tpc  = tgt;
                end else begin
                    m.pc = tgt;
                end
            end else if (!st) begin
                m.valid = 1'b1;
                m.ipc   = m.pc;
                m.ipc4  = m.pc + 32'd4;
                m.inst  = mem_word(m.pc);
                m.pc    = m.pc + 32'd4;
                m.cnt   = m.cnt + 32'd1;
            end
        end else begin
            if (rd) begin
                if (tgt[1:0] != 2'b00) begin
                    m.tpc = tgt;
                end else begin
                    m_trap_state = 1'b0;
                    m.trap = 1'b0;
                    m.pc   = tgt;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, push expectation, compare after the edge.
    task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        rst = r; stall_s = st; redirect_s = rd; redirect_pc_s = tgt;
        model_step(r, st, rd, tgt);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks_cnt++;
            fail_cnt++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = exp_q.pop_front();
            check_val("pc",        pc_s,                 e.pc);
            check_val("pc_align",  {30'd0, pc_s[1:0]},   32'd0);
            check_val("valid",     {31'd0, ifid_valid_s}, {31'd0, e.valid});
            check_val("ifid_pc",   ifid_pc_s,            e.ipc);
            check_val("ifid_pc4",  ifid_pc4_s,           e.ipc4);
            check_val("ifid_inst", ifid_inst_s,          e.inst);
            check_val("trap",      {31'd0, trap_s},      {31'd0, e.trap});
            check_val("trap_pc",   trap_pc_s,            e.tpc);
            check_val("fetch_cnt", fetch_cnt_s,          e.cnt);
        end
    endtask

    initial begin
        m_trap_state = 1'b0;
        m = '{pc: 32'd0, valid: 1'b0, ipc: 32'd0, ipc4: 32'd0, inst: NOP,
              trap: 1'b0, tpc: 32'd0, cnt: 32'd0};
        rst = 1'b1; stall_s = 1'b0; redirect_s = 1'b0; redirect_pc_s = 32'd0;

        // 1. reset then four sequential fetches
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        check_val("rst_inst", ifid_inst_s, 32'h0000_0013);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t1_pc", pc_s, 32'h0000_0010);
        check_val("t1_ifid_inst", ifid_inst_s, mem_word(32'h0000_000C));
        check_val("t1_cnt", fetch_cnt_s, 32'd4);

        // 2. stall three cycles at pc 0x8
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check_val("t2_pc_hold", pc_s, 32'h0000_0008);
        check_val("t2_ifid_pc", ifid_pc_s, 32'h0000_0004);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t2_release", ifid_pc_s, 32'h0000_0008);

        // 3. redirect beats stall
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        check_val("t3_pc", pc_s, 32'h0000_0040);
        check_val("t3_flush", ifid_inst_s, 32'h0000_0013);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t3_ifid_pc", ifid_pc_s, 32'h0000_0040);

        // 4. misaligned redirect traps; idle cycles ignore stall; re-trap; recover
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0042);
        check_val("t4_trap_pc", trap_pc_s, 32'h0000_0042);
        for (int i = 0; i < 5; i++) cycle(1'b0, i[0], 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0083);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        check_val("t4_pc", pc_s, 32'h0000_0080);
        check_val("t4_trap_pc_kept", trap_pc_s, 32'h0000_0083);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // 5. wrap at the top of the address space
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_val("t5_pc4", ifid_pc4_s, 32'h0000_0000);
        check_val("t5_pc", pc_s, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);

        // 6. reset beats redirect and stall
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        check_val("t6_cnt", fetch_cnt_s, 32'd0);
        check_val("t6_pc", pc_s, 32'h0000_0000);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            logic rd;
            logic [31:0] tgt;
            rd  = ($urandom_range(0, 7) == 0);
            tgt = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), rd, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
